// File: rtl/sha_pkg.sv
// Shared types and sizing for the SHA-256 front end.
// A block is NIBBLES nibbles of NIB_W bits; nibble k occupies bits [NIB_W*k +: NIB_W].
package sha_pkg;

    localparam int NIBBLES = 128;
    localparam int NIB_W   = 4;
    localparam int BLOCK_W = NIBBLES * NIB_W;

    typedef logic [NIB_W-1:0]   nibble_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } asm_state_e;

endpackage

// File: rtl/nibble_to_block.sv
// Packs a valid/ready stream of nibbles into one message block and hands it
// downstream over valid/ready; in_last closes a block early, unused nibbles read 0.
module nibble_to_block
    import sha_pkg::*;
#(
    parameter int NIBBLES = sha_pkg::NIBBLES,
    parameter int NIB_W   = sha_pkg::NIB_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [NIB_W-1:0]           in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [NIBBLES*NIB_W-1:0]   out_block,
    output logic [7:0]                 out_count,
    output logic                       out_last,
    input  logic                       out_ready,
    output asm_state_e                 dbg_state
);

    localparam int BLK_W = NIBBLES * NIB_W;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; the producer holds data stable until that edge.
    asm_state_e         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLK_W-1:0]   buf_q;
    logic               out_valid_q;
    logic [7:0]         out_count_q;
    logic               out_last_q;

    assign in_ready  = (state_q == FILL) && !rst;
    assign out_valid = out_valid_q;
    assign out_block = buf_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid && in_ready) begin
                        buf_q[idx_q*NIB_W +: NIB_W] <= in_data;
                        // idx is held at the final slot rather than wrapped; release re-zeroes it.
                        if (idx_q == LAST_IDX || in_last) begin
                            state_q     <= FULL;
                            out_valid_q <= 1'b1;
                            out_count_q <= 8'(idx_q) + 8'd1;
                            out_last_q  <= in_last;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= FILL;
                        idx_q       <= '0;
                        buf_q       <= '0;
                        out_valid_q <= 1'b0;
                        out_count_q <= '0;
                        out_last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule
